stream_max_tracker: RTL

- Sequential front stage for the 8-bit unsigned maximum comparator.
- Accepts a stream of WIDTH-bit unsigned samples over a valid/ready handshake, with each frame delimited by in_last.
- Keeps a running maximum, a running minimum, the index of the maximum and a sample count.
- Presents the frame result with a valid/ready handshake to the consumer downstream.

---
 rtl/stream_max_tracker.sv | 129 ++++++++++++
 1 files changed

// File: rtl/stream_max_tracker.sv
`default_nettype none
// ============================================================================
// Module   : stream_max_tracker
// Purpose  : Tracks the max/min, the index of the first max and the sample
//            count over a framed valid/ready stream; the result is held for
//            downstream.
// Revision : 1.0 - initial release
// ============================================================================
module stream_max_tracker #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min,
  output logic [CNT_W:0]   out_idx,
  output logic [CNT_W:0]   out_count,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [CNT_W:0] c_cnt_max  = {1'b1, {CNT_W{1'b0}}};
  localparam logic [CNT_W:0] c_cnt_one  = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W:0] c_cnt_zero = '0;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [CNT_W:0]   idx_q, idx_d;
  logic [CNT_W:0]   count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic             w_xfer;

  assign in_ready = (state_q == ACC) && !rst;
  assign w_xfer   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    min_d   = min_q;
    idx_d   = idx_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    case (state_q)
      ACC: begin
        if (w_xfer) begin
          if (count_q == c_cnt_zero) begin
            max_d   = in_data;
            min_d   = in_data;
            idx_d   = c_cnt_zero;
            count_d = c_cnt_one;
            ovf_d   = 1'b0;
          end else begin
            // Strict compare keeps the earliest index on ties.
            if (in_data > max_q) begin
              max_d = in_data;
              idx_d = count_q;
            end
            if (in_data < min_q) begin
              min_d = in_data;
            end
            if (count_q == c_cnt_max) begin
              ovf_d = 1'b1;
            end else begin
              count_d = count_q + c_cnt_one;
            end
          end
          if (in_last) begin
            state_d = HOLD;
            valid_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACC;
          valid_d = 1'b0;
          count_d = c_cnt_zero;
          ovf_d   = 1'b0;
        end
      end
      default: begin
        state_d = ACC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
      max_q   <= '0;
      min_q   <= '0;
      idx_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      min_q   <= min_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign out_max   = max_q;
  assign out_min   = min_q;
  assign out_idx   = idx_q;
  assign out_count = count_q;
  assign out_ovf   = ovf_q;
  assign out_valid = valid_q;

endmodule
`default_nettype wire
